// File: rtl/poly_pkg.sv
// Shared constants, FSM state type and status codes for the polynomial-evaluation accelerator.
package poly_pkg;

  localparam int MAX_DEG   = 10;
  localparam int SLOT_SIZE = 11;
  localparam int NUM_SLOTS = 8;

  typedef enum logic [2:0] {
    IDLE,
    COMPUTE0,
    COMPUTE1,
    COMPUTE2,
    DONE
  } stp_state_t;

  localparam logic [31:0] STATUS_OK      = 32'd0;
  localparam logic [31:0] STATUS_BAD_DEG = 32'd1;

  function automatic logic [4:0] sat_deg(input logic [4:0] n);
    return (n > 5'(MAX_DEG)) ? 5'(MAX_DEG) : n;
  endfunction

endpackage

// File: rtl/stp_addr_gen.sv
// Coefficient address within S: slot a occupies words a*11 .. a*11+10 (shift-add form).
module stp_addr_gen #(
  parameter int AW = 10
) (
  input  logic [2:0]    a,
  input  logic [3:0]    i,
  output logic [AW-1:0] addr
);

  logic [6:0] sum;

  assign sum  = 7'({a, 3'b000}) + 7'({a, 1'b0}) + 7'(a) + 7'(i);
  assign addr = AW'(sum);

endmodule

// File: rtl/stp_fsm.sv
// STP controller: records degree N for slot A, then copies N+1 coefficients from the data buffer into S.
// Optional build macro STP_DEGREE_CHECK_EN rejects N > 10; without it N is saturated to 10.
//
// state    | meaning
// IDLE     | waiting for start_stp, outputs quiet
// COMPUTE0 | write degree to N memory, prefetch first coefficient (or reject degree)
// COMPUTE1 | fetch next coefficient from the data buffer
// COMPUTE2 | write fetched coefficient to S, advance pointer
// DONE     | one-cycle done_stp pulse, result/status valid
module stp_fsm
  import poly_pkg::*;
#(
  parameter int word_size   = 16,
  parameter int buffer_size = 1024,
  localparam int AW         = $clog2(buffer_size)
) (
  input  logic                 clk,
  input  logic                 rst,
  input  logic                 rst_instr,
  input  logic                 start_stp,
  input  logic [AW-1:0]        rd_addr_data,
  input  logic [2:0]           A,
  input  logic [4:0]           N,
  input  logic [word_size-1:0] next_c,
  output logic                 done_stp,
  output logic                 en_rd_data,
  output logic                 en_rd_S,
  output logic                 en_rd_N,
  output logic [AW-1:0]        rd_addr_data_updated,
  output logic [AW-1:0]        wr_addr_S,
  output logic [AW-1:0]        wr_addr_N,
  output logic [word_size-1:0] c,
  output logic [31:0]          result,
  output logic [31:0]          status
);

  stp_state_t    state, state_nxt;
  logic [2:0]    a_q;
  logic [4:0]    n_q;
  logic [3:0]    i;
  logic [AW-1:0] ptr;
  logic [31:0]   result_q, status_q;
  logic [AW-1:0] addr_s;
  logic [4:0]    deg_in;
  logic          bad_deg;
  logic          i_last;

`ifdef STP_DEGREE_CHECK_EN
  assign deg_in  = N;
  assign bad_deg = (n_q > 5'(MAX_DEG));
`else
  assign deg_in  = sat_deg(N);
  assign bad_deg = 1'b0;
`endif

  assign i_last = ({1'b0, i} == n_q);

  stp_addr_gen #(.AW(AW)) u_addr_gen (
    .a    (a_q),
    .i    (i),
    .addr (addr_s)
  );

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= IDLE;
      a_q      <= '0;
      n_q      <= '0;
      i        <= '0;
      ptr      <= '0;
      result_q <= '0;
      status_q <= '0;
    end else if (!rst_instr) begin
      state    <= IDLE;
      a_q      <= '0;
      n_q      <= '0;
      i        <= '0;
      ptr      <= '0;
      result_q <= '0;
      status_q <= '0;
    end else begin
      state <= state_nxt;
      case (state)
        IDLE: begin
          if (start_stp) begin
            a_q      <= A;
            n_q      <= deg_in;
            ptr      <= rd_addr_data;
            i        <= '0;
            result_q <= '0;
            status_q <= '0;
          end
        end
        COMPUTE0: begin
          if (bad_deg) begin
            result_q <= '0;
            status_q <= STATUS_BAD_DEG;
          end
        end
        COMPUTE2: begin
          // explicit wrap keeps non-power-of-two buffer depths correct
          ptr <= (ptr == AW'(buffer_size - 1)) ? '0 : ptr + 1'b1;
          if (i_last) begin
            result_q <= 32'(n_q) + 32'd1;
            status_q <= STATUS_OK;
          end else begin
            i <= i + 4'd1;
          end
        end
        default: ;
      endcase
    end
  end

  always_comb begin
    state_nxt  = state;
    done_stp   = 1'b0;
    en_rd_data = 1'b0;
    en_rd_S    = 1'b0;
    en_rd_N    = 1'b0;
    wr_addr_S  = '0;
    wr_addr_N  = '0;
    c          = '0;
    case (state)
      IDLE: begin
        if (start_stp) state_nxt = COMPUTE0;
      end
      COMPUTE0: begin
        if (bad_deg) begin
          state_nxt = DONE;
        end else begin
          en_rd_N    = 1'b1;
          wr_addr_N  = AW'(a_q);
          c          = word_size'(n_q);
          en_rd_data = 1'b1;
          state_nxt  = COMPUTE2;
        end
      end
      COMPUTE2: begin
        en_rd_S   = 1'b1;
        wr_addr_S = addr_s;
        c         = next_c;
        state_nxt = i_last ? DONE : COMPUTE1;
      end
      COMPUTE1: begin
        en_rd_data = 1'b1;
        state_nxt  = COMPUTE2;
      end
      DONE: begin
        done_stp  = 1'b1;
        state_nxt = IDLE;
      end
      default: state_nxt = IDLE;
    endcase
  end

  assign rd_addr_data_updated = ptr;
  assign result               = result_q;
  assign status               = status_q;

endmodule

// File: tb/tb_stp_fsm.sv
// Self-checking bench for stp_fsm: vector table, randomized transactions against a rule-level model, abort and reset sequences.
module tb_stp_fsm;

  localparam int AW = 10;

  logic          clk = 1'b0;
  logic          rst;
  logic          rst_instr;
  logic          start_stp;
  logic [AW-1:0] rd_addr_data;
  logic [2:0]    A;
  logic [4:0]    N;
  logic [15:0]   next_c = '0;
  logic          done_stp, en_rd_data, en_rd_S, en_rd_N;
  logic [AW-1:0] rd_addr_data_updated, wr_addr_S, wr_addr_N;
  logic [15:0]   c;
  logic [31:0]   result, status;

  stp_fsm dut (
    .clk                  (clk),
    .rst                  (rst),
    .rst_instr            (rst_instr),
    .start_stp            (start_stp),
    .rd_addr_data         (rd_addr_data),
    .A                    (A),
    .N                    (N),
    .next_c               (next_c),
    .done_stp             (done_stp),
    .en_rd_data           (en_rd_data),
    .en_rd_S              (en_rd_S),
    .en_rd_N              (en_rd_N),
    .rd_addr_data_updated (rd_addr_data_updated),
    .wr_addr_S            (wr_addr_S),
    .wr_addr_N            (wr_addr_N),
    .c                    (c),
    .result               (result),
    .status               (status)
  );

  always #5 clk = ~clk;

  // data buffer model: word appears the cycle after the read request
  logic [15:0] buf_mem [1024];
  always @(posedge clk) if (en_rd_data) next_c <= buf_mem[rd_addr_data_updated];

  int n_checks = 0;
  int n_errors = 0;

  task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
    n_checks++;
    if (act !== exp) begin
      n_errors++;
      $display("FAIL %s: got %0d, expected %0d", name, act, exp);
    end
  endtask

  typedef struct {
    int a;
    int n;
    int rd;
    int exp_result;
    int exp_status;
    int exp_ptr;
    int exp_lat;
  } vec_t;

  // effective degree stored, or -1 when the degree is rejected
  function automatic int model_deg(input int n);
`ifdef STP_DEGREE_CHECK_EN
    return (n > 10) ? -1 : n;
`else
    return (n > 10) ? 10 : n;
`endif
  endfunction

  function automatic vec_t model_vec(input int a, input int n, input int rd);
    vec_t v;
    int d;
    d = model_deg(n);
    v.a = a; v.n = n; v.rd = rd;
    if (d < 0) begin
      v.exp_result = 0; v.exp_status = 1; v.exp_ptr = rd; v.exp_lat = 2;
    end else begin
      v.exp_result = d + 1; v.exp_status = 0;
      v.exp_ptr = (rd + d + 1) % 1024; v.exp_lat = 3 + 2 * d;
    end
    return v;
  endfunction

  task automatic do_txn(input string tag, input vec_t v);
    int s_addr[$];
    int s_data[$];
    int n_wr, n_addr, n_data, lat, d, nexp;
    logic [31:0] d_res, d_stat, d_ptr;
    n_wr = 0; n_addr = 0; n_data = 0; lat = -1;
    d_res = '0; d_stat = '0; d_ptr = '0;
    d = model_deg(v.n);
    @(negedge clk);
    A = 3'(v.a); N = 5'(v.n); rd_addr_data = AW'(v.rd); start_stp = 1'b1;
    for (int cyc = 1; cyc <= 40; cyc++) begin
      @(negedge clk);
      if (cyc == 1) start_stp = 1'b0;
      if (en_rd_S) begin s_addr.push_back(int'(wr_addr_S)); s_data.push_back(int'(c)); end
      if (en_rd_N) begin n_wr++; n_addr = int'(wr_addr_N); n_data = int'(c); end
      if (done_stp) begin
        lat = cyc; d_res = result; d_stat = status; d_ptr = 32'(rd_addr_data_updated);
        break;
      end
      // a start while busy must be ignored, as must changes on A/N
      if (cyc == 2) begin start_stp = 1'b1; A = ~3'(v.a); N = 5'd1; end
      else if (cyc == 3) begin start_stp = 1'b0; A = 3'(v.a); N = 5'(v.n); end
    end
    start_stp = 1'b0;
    check({tag, ".latency"}, lat, v.exp_lat);
    check({tag, ".result"}, d_res, v.exp_result);
    check({tag, ".status"}, d_stat, v.exp_status);
    check({tag, ".ptr"}, d_ptr, v.exp_ptr);
    nexp = (d < 0) ? 0 : d + 1;
    check({tag, ".n_writes"}, n_wr, (d < 0) ? 0 : 1);
    if (d >= 0) begin
      check({tag, ".n_addr"}, n_addr, v.a);
      check({tag, ".n_data"}, n_data, d);
    end
    check({tag, ".s_count"}, s_addr.size(), nexp);
    for (int k = 0; k < s_addr.size() && k < nexp; k++) begin
      check($sformatf("%s.s_addr%0d", tag, k), s_addr[k], v.a * 11 + k);
      check($sformatf("%s.s_data%0d", tag, k), s_data[k], int'(buf_mem[(v.rd + k) % 1024]));
    end
    @(negedge clk);
    check({tag, ".done_pulse"}, done_stp, 0);
    check({tag, ".result_hold"}, result, v.exp_result);
    check({tag, ".status_hold"}, status, v.exp_status);
    check({tag, ".ptr_idle"}, rd_addr_data_updated, v.exp_ptr);
  endtask

  task automatic check_quiet(input string tag);
    check({tag, ".strobes"}, {28'd0, done_stp, en_rd_data, en_rd_S, en_rd_N}, 0);
    check({tag, ".ptr"}, rd_addr_data_updated, 0);
    check({tag, ".waddr"}, {wr_addr_S, wr_addr_N}, 0);
    check({tag, ".c"}, c, 0);
    check({tag, ".result"}, result, 0);
    check({tag, ".status"}, status, 0);
  endtask

  vec_t vecs[5];

  initial begin
    int dones;
    rst = 1'b1; rst_instr = 1'b1; start_stp = 1'b0;
    rd_addr_data = '0; A = '0; N = '0;
    for (int k = 0; k < 1024; k++) buf_mem[k] = 16'($urandom);
    buf_mem[0] = 16'd3; buf_mem[1] = 16'd4; buf_mem[2] = 16'd2; buf_mem[3] = 16'd1;

    vecs[0] = '{0, 3, 0, 4, 0, 4, 9};
    vecs[1] = '{7, 10, 1020, 11, 0, 7, 23};
    vecs[2] = '{2, 0, 500, 1, 0, 501, 3};
`ifdef STP_DEGREE_CHECK_EN
    vecs[3] = '{3, 12, 200, 0, 1, 200, 2};
    vecs[4] = '{5, 31, 1023, 0, 1, 1023, 2};
`else
    vecs[3] = '{3, 12, 200, 11, 0, 211, 23};
    vecs[4] = '{5, 31, 1023, 11, 0, 10, 23};
`endif

    repeat (2) @(negedge clk);
    check_quiet("reset");
    rst = 1'b0;
    repeat (3) @(negedge clk);
    check_quiet("post_reset");

    for (int t = 0; t < 5; t++) do_txn($sformatf("vec%0d", t), vecs[t]);

    for (int t = 0; t < 25; t++)
      do_txn($sformatf("rand%0d", t),
             model_vec(int'($urandom_range(0, 7)), int'($urandom_range(0, 15)),
                       int'($urandom_range(0, 1023))));

    // abort in the fetch state of an N=5 store
    @(negedge clk);
    A = 3'd1; N = 5'd5; rd_addr_data = 10'd100; start_stp = 1'b1;
    @(negedge clk); start_stp = 1'b0;
    @(negedge clk);
    @(negedge clk);
    check("abort.in_fetch", {en_rd_data, en_rd_S}, 2'b10);
    rst_instr = 1'b0;
    @(negedge clk);
    check_quiet("abort");
    rst_instr = 1'b1;
    dones = 0;
    repeat (30) begin
      @(negedge clk);
      if (done_stp) dones++;
    end
    check("abort.no_done", dones, 0);
    do_txn("after_abort", model_vec(4, 6, 1021));

    $display("Simulation finished: %0d checks, %0d errors", n_checks, n_errors);
    $finish;
  end

  initial begin
    #1000000;
    $display("FAIL watchdog: simulation time limit reached");
    $fatal(1, "timeout");
  end

endmodule

// File: doc/stp_fsm.md
Name: stp_fsm

Overview:
- Controller for the STP (store polynomial) instruction of the polynomial-evaluation accelerator.
- On start, it records degree N for polynomial slot A in the N memory.
- It then copies N+1 coefficients from the input data buffer into the coefficient memory S.
- The instruction decoder starts it; the decoder's memories and data buffer are driven from its enable/address outputs.

Parameters:
word_size, 16, width of one coefficient word
buffer_size, 1024, depth of input data buffer; AW = clog2(buffer_size) = 10

Ports:
clk  in  1  system clock
rst  in  1  asynchronous active-high reset
rst_instr  in  1  active-low synchronous instruction reset; 0 forces IDLE, 1 = normal operation
start_stp  in  1  start request, sampled in IDLE
rd_addr_data  in  AW  current read pointer into data buffer
A  in  3  polynomial slot (0..7)
N  in  5  polynomial degree
next_c  in  word_size  data-buffer word at rd_addr_data_updated (valid the cycle after en_rd_data)
done_stp  out  1  one-cycle completion pulse
en_rd_data  out  1  data-buffer read request
en_rd_S  out  1  S-memory write enable
en_rd_N  out  1  N-memory write enable
rd_addr_data_updated  out  AW  advanced data-buffer pointer
wr_addr_S  out  AW  S-memory address
wr_addr_N  out  AW  N-memory address
c  out  word_size  write data for S or N memory
result  out  32  instruction result
status  out  32  instruction status

Behaviour:
- Constants: MAX_DEG = 10, SLOT_SIZE = 11. S holds 88 words, N holds 8 words.
- Registers: a_q, n_q, i (coefficient index 0..10), ptr (AW bits), state.
- Reset (rst=1, async, or rst_instr=0, sync): state=IDLE, i=0, ptr=0, a_q=0, n_q=0.
  - All outputs 0 during and after reset until start.
- States:
  - IDLE:
    - Outputs 0; rd_addr_data_updated = ptr.
    - If start_stp: latch a_q=A, n_q=N, ptr=rd_addr_data, i=0; go COMPUTE0.
  - COMPUTE0:
    - If n_q > MAX_DEG: status = 1, result = 0; go DONE. No memory writes.
    - Else: en_rd_N=1, wr_addr_N=a_q, c = zero-extended n_q.
    - Also en_rd_data=1 to prefetch the first coefficient; go COMPUTE2.
  - COMPUTE2 (write):
    - en_rd_S=1, wr_addr_S = a_q*11 + i, c = next_c.
    - ptr <= ptr+1 (mod buffer_size).
    - If i == n_q: go DONE. Else i <= i+1, go COMPUTE1.
  - COMPUTE1 (fetch):
    - en_rd_data=1 with rd_addr_data_updated = ptr; go COMPUTE2.
  - DONE:
    - done_stp=1 for exactly one cycle.
    - On success: status = 0, result = n_q+1 (coefficients stored).
    - Return to IDLE.
- rd_addr_data_updated always equals ptr; its value after DONE is the pointer for the next instruction.
- result and status hold their values until the next start_stp.
- Latency for a valid N: 2 + 2N + 1 cycles from start to done_stp.
  - N=0 gives 3 cycles; N=3 gives 9 cycles.
- Pointer wrap: ptr wraps from buffer_size-1 to 0.
- start_stp outside IDLE is ignored.
- rst_instr low mid-operation aborts with no done pulse.
  - Writes already issued are not undone.

Optional Feature:
- Macro STP_DEGREE_CHECK_EN.
- Defined: N > 10 yields status=1, result=0, no S/N writes, done_stp pulses after COMPUTE0 (latency 2 cycles).
- Undefined: no check is performed.
  - n_q is taken modulo SLOT_SIZE range by saturating to 10.
  - status is always 0.

Decomposition:
- Shared package poly_pkg holds: MAX_DEG, SLOT_SIZE, NUM_SLOTS=8, state enum (IDLE, COMPUTE0, COMPUTE1, COMPUTE2, DONE), STATUS_OK=0, STATUS_BAD_DEG=1.
- One sub-module is natural: stp_addr_gen, computing a_q*11+i (shift-add: a*8+a*2+a+i).

Test Plan:
- Reset: assert rst → all outputs 0, state IDLE. Deassert with start_stp=0 → outputs stay 0.
- Basic store: A=0, N=3, rd_addr_data=0, next_c stream 3,4,2,1.
  - en_rd_N with wr_addr_N=0, c=3.
  - en_rd_S at wr_addr_S 0,1,2,3 with c=3,4,2,1 on alternate cycles.
  - done_stp one cycle later; result=4, status=0, rd_addr_data_updated=4.
- Slot offset: A=7, N=10, rd_addr_data=1020.
  - S writes at 77..87.
  - Pointer wraps to 7 at end; result=11.
- Degree zero: A=2, N=0 → one S write at 22, done_stp 3 cycles after start, result=1.
- Bad degree (STP_DEGREE_CHECK_EN defined): N=12 → no en_rd_S/en_rd_N, status=1, result=0, done_stp on 2nd cycle.
- Abort: rst_instr=0 during COMPUTE1 of N=5 → IDLE next cycle, no done_stp. A new start then completes normally.
